exec_sequencer: RTL and testbench
=================================

// Module: exec_sequencer
// PURPOSE
//  Multi-cycle execute controller for the 16-bit datapath. Accepts one instruction
//  (op, rd, rs, rt) via valid/ready, reads operands from the 8x16 register bank,
//  drives the ALU function code, and writes the result back to the bank.
//  Maintains the Z/S/C/V status flags, and pulses done once per retired instruction.
// PARAMETERS
//  DW    16  datapath width (the ALU and register bank are 16-bit; other values are unsupported)
//  RSELW 3   register-select width (8 registers)
// PORTS
//  clock       in   1     single clock; all state updates on posedge
//  reset       in   1     asynchronous, active-high reset
//  instr_valid in   1     instruction offered
//  instr_ready out  1     sequencer can accept (high only in IDLE)
//  instr_op    in   3     ALU code: 000 pass, 001 inc, 010 add, 011 neg, 100 or, 101 not, 110 dec, 111 illegal
//  instr_rd    in   3     destination register
//  instr_rs    in   3     source X register
//  instr_rt    in   3     source Y register (used only by 010 and 100)
//  reg_sel     out  3     bank register select
//  reg_read    out  1     bank read strobe
//  reg_write   out  1     bank write enable (bank samples on posedge)
//  reg_wdata   out  16    bank write data
//  reg_rdata   in   16    bank read data, combinational from reg_sel
//  alu_x       out  16    ALU operand X
//  alu_y       out  16    ALU operand Y
//  alu_f       out  3     ALU function
//  alu_z       in   16    ALU result, combinational
//  alu_cy      in   1     ALU carry out
//  busy        out  1     high in any state other than IDLE
//  done        out  1     one-cycle pulse per retired instruction
//  illegal     out  1     one-cycle pulse, coincident with done, for op 111
//  flags       out  4     {Z,S,C,V}, registered
// BEHAVIOUR
//  Reset (async): state=IDLE; x_q/y_q/z_q/op_q=0; flags=0. Because outputs are decoded from state,
//   reg_write, reg_read, done and illegal drop immediately. An in-flight instruction is discarded and not written back.
//  IDLE: instr_ready=1. On valid&ready at a posedge: latch op/rd/rs/rt, go to RDX.
//  RDX: reg_sel=rs, reg_read=1; posedge latches x_q<=reg_rdata. Next state is RDY if op is 010 or 100, else EXEC.
//  RDY: reg_sel=rt, reg_read=1; posedge latches y_q<=reg_rdata; next state EXEC.
//  EXEC: alu_x=x_q, alu_y=y_q, alu_f=op_q; posedge latches z_q<=alu_z and updates flags.
//   Next state is WB, except op 111: no flag update, next state IDLE, with done=illegal=1 during EXEC.
//  WB: reg_sel=rd, reg_write=1, reg_wdata=z_q, done=1; next state IDLE.
//  Outside EXEC: alu_f=000 and alu_x/alu_y hold x_q/y_q. Outside RDX/RDY/WB: reg_sel=0.
//   reg_read/reg_write are 0 except in the states listed above. y_q is 0 for single-operand ops (cleared at accept).
//  Latency, accept edge to the done cycle: 4 cycles (add/or), 3 cycles (other ops), 2 cycles (op 111).
//   No new accept until IDLE is re-entered; max throughput is one instruction per 4 or 5 cycles.
//  Flags (updated in EXEC only):
//   Z=(alu_z==0); S=alu_z[15].
//   C: alu_cy for 001/010/110; (x_q!=0) for 011; 0 for 000/100/101.
//   V: add: x15==y15 && z15!=x15. inc: x_q==16'h7FFF. dec and neg: x_q==16'h8000. Others: 0.
//  Wrap: inc 16'hFFFF -> 0 with Z=1,C=1. dec 0 -> 16'hFFFF with S=1. All arithmetic is mod 2^16.
//  rd may equal rs/rt. Operands are latched before WB, so read-after-write within an instruction is safe.
//  instr_valid while busy is ignored (ready=0); the offering side must hold it.
// TESTING (bench: this block plus behavioural 8x16 bank and ALU models)
//  R1=5,R2=7; add rd=R3 rs=R1 rt=R2 -> R3=12, flags=0000, done 4 cycles after accept.
//  R1=16'h7FFF; inc rd=R1 rs=R1 -> R1=16'h8000, S=1,V=1,Z=0, done after 3 cycles, no RDY state visited.
//  R4=16'hFFFF; inc rd=R5 rs=R4 -> R5=0, Z=1,C=1; then dec rs=R5 rd=R6 -> R6=16'hFFFF, S=1.
//  op 111 with rd=R2 (R2=9) -> illegal+done pulse 2 cycles after accept; R2 stays 9; flags unchanged.
//  Assert reset during RDY of an add -> reg_write never asserts, flags=0, instr_ready=1 after release.
//  Back-to-back valid held high for 3 instrs -> exactly 3 done pulses; ready low throughout each execution.

Source files
------------

// File: rtl/exec_sequencer.sv
// Multi-cycle execute controller: fetches operands from an 8x16 register bank,
// drives the ALU, writes the result back and maintains Z/S/C/V status flags.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | ready for a new instruction
// RDX   | read source X (rs) from the bank into x_q
// RDY   | read source Y (rt) into y_q; visited only for add and or
// EXEC  | present operands to the ALU, capture result and flags
// WB    | write z_q back to rd and signal done
module exec_sequencer #(
    parameter int DW    = 16,
    parameter int RSELW = 3
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             instr_valid,
    output logic             instr_ready,
    input  logic [2:0]       instr_op,
    input  logic [RSELW-1:0] instr_rd,
    input  logic [RSELW-1:0] instr_rs,
    input  logic [RSELW-1:0] instr_rt,
    output logic [RSELW-1:0] reg_sel,
    output logic             reg_read,
    output logic             reg_write,
    output logic [DW-1:0]    reg_wdata,
    input  logic [DW-1:0]    reg_rdata,
    output logic [DW-1:0]    alu_x,
    output logic [DW-1:0]    alu_y,
    output logic [2:0]       alu_f,
    input  logic [DW-1:0]    alu_z,
    input  logic             alu_cy,
    output logic             busy,
    output logic             done,
    output logic             illegal,
    output logic [3:0]       flags
);

    localparam logic [2:0] OP_PASS = 3'b000;
    localparam logic [2:0] OP_INC  = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_NEG  = 3'b011;
    localparam logic [2:0] OP_OR   = 3'b100;
    localparam logic [2:0] OP_NOT  = 3'b101;
    localparam logic [2:0] OP_DEC  = 3'b110;
    localparam logic [2:0] OP_ILL  = 3'b111;

    localparam logic [DW-1:0] MAX_POS = {1'b0, {(DW-1){1'b1}}};
    localparam logic [DW-1:0] MIN_NEG = {1'b1, {(DW-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RDX  = 3'd1,
        S_RDY  = 3'd2,
        S_EXEC = 3'd3,
        S_WB   = 3'd4
    } state_t;

    state_t state, state_nxt;

    logic [2:0]       op_q;
    logic [RSELW-1:0] rd_q, rs_q, rt_q;
    logic [DW-1:0]    x_q, y_q, z_q;
    logic [3:0]       flags_q;
    logic [3:0]       flags_nxt;
    logic             accept;
    logic             two_operand;
    logic             flag_c, flag_v;

    assign accept      = (state == S_IDLE) && instr_valid;
    assign two_operand = (op_q == OP_ADD) || (op_q == OP_OR);

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (instr_valid) state_nxt = S_RDX;
            S_RDX:  state_nxt = two_operand ? S_RDY : S_EXEC;
            S_RDY:  state_nxt = S_EXEC;
            S_EXEC: state_nxt = (op_q == OP_ILL) ? S_IDLE : S_WB;
            S_WB:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Outputs decoded purely from state so reset drops them immediately
    always_comb begin
        instr_ready = 1'b0;
        busy        = 1'b1;
        reg_sel     = '0;
        reg_read    = 1'b0;
        reg_write   = 1'b0;
        alu_f       = OP_PASS;
        done        = 1'b0;
        illegal     = 1'b0;
        case (state)
            S_IDLE: begin
                instr_ready = 1'b1;
                busy        = 1'b0;
            end
            S_RDX: begin
                reg_sel  = rs_q;
                reg_read = 1'b1;
            end
            S_RDY: begin
                reg_sel  = rt_q;
                reg_read = 1'b1;
            end
            S_EXEC: begin
                alu_f = op_q;
                if (op_q == OP_ILL) begin
                    done    = 1'b1;
                    illegal = 1'b1;
                end
            end
            S_WB: begin
                reg_sel   = rd_q;
                reg_write = 1'b1;
                done      = 1'b1;
            end
            default: ;
        endcase
    end

    assign alu_x     = x_q;
    assign alu_y     = y_q;
    assign reg_wdata = z_q;
    assign flags     = flags_q;

    // Carry and overflow depend on the operation; Z and S come straight from the result
    always_comb begin
        flag_c = 1'b0;
        flag_v = 1'b0;
        case (op_q)
            OP_INC: begin
                flag_c = alu_cy;
                flag_v = (x_q == MAX_POS);
            end
            OP_ADD: begin
                flag_c = alu_cy;
                flag_v = (x_q[DW-1] == y_q[DW-1]) && (alu_z[DW-1] != x_q[DW-1]);
            end
            OP_DEC: begin
                flag_c = alu_cy;
                flag_v = (x_q == MIN_NEG);
            end
            OP_NEG: begin
                flag_c = (x_q != '0);
                flag_v = (x_q == MIN_NEG);
            end
            OP_PASS, OP_OR, OP_NOT, OP_ILL: ;
            default: ;
        endcase
        flags_nxt = {(alu_z == '0), alu_z[DW-1], flag_c, flag_v};
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            op_q    <= '0;
            rd_q    <= '0;
            rs_q    <= '0;
            rt_q    <= '0;
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
            flags_q <= '0;
        end else begin
            if (accept) begin
                op_q <= instr_op;
                rd_q <= instr_rd;
                rs_q <= instr_rs;
                rt_q <= instr_rt;
                y_q  <= '0;
            end
            if (state == S_RDX) x_q <= reg_rdata;
            if (state == S_RDY) y_q <= reg_rdata;
            if (state == S_EXEC && op_q != OP_ILL) begin
                z_q     <= alu_z;
                flags_q <= flags_nxt;
            end
        end
    end

endmodule

// File: tb/tb_exec_sequencer.sv
// Bench for exec_sequencer with behavioural 8x16 register bank and ALU models.
module tb_exec_sequencer;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        instr_valid = 1'b0;
    logic        instr_ready;
    logic [2:0]  instr_op = '0, instr_rd = '0, instr_rs = '0, instr_rt = '0;
    logic [2:0]  reg_sel;
    logic        reg_read, reg_write;
    logic [15:0] reg_wdata, reg_rdata;
    logic [15:0] alu_x, alu_y, alu_z;
    logic [2:0]  alu_f;
    logic        alu_cy;
    logic        busy, done, illegal;
    logic [3:0]  flags;

    logic [15:0] bank [8];
    logic        pre_we = 1'b0;
    logic [2:0]  pre_sel = '0;
    logic [15:0] pre_data = '0;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clock = ~clock;

    exec_sequencer #(.DW(16), .RSELW(3)) dut (
        .clock(clock), .reset(reset),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_op(instr_op), .instr_rd(instr_rd), .instr_rs(instr_rs), .instr_rt(instr_rt),
        .reg_sel(reg_sel), .reg_read(reg_read), .reg_write(reg_write),
        .reg_wdata(reg_wdata), .reg_rdata(reg_rdata),
        .alu_x(alu_x), .alu_y(alu_y), .alu_f(alu_f), .alu_z(alu_z), .alu_cy(alu_cy),
        .busy(busy), .done(done), .illegal(illegal), .flags(flags)
    );

    assign reg_rdata = bank[reg_sel];

    always @(posedge clock) begin
        if (reg_write)   bank[reg_sel] <= reg_wdata;
        else if (pre_we) bank[pre_sel] <= pre_data;
    end

    // ALU model; dec carry is the carry out of x + 16'hFFFF
    logic [16:0] sum;
    always_comb begin
        sum    = '0;
        alu_z  = alu_x;
        alu_cy = 1'b0;
        case (alu_f)
            3'b001: begin sum = {1'b0, alu_x} + 17'd1;       alu_z = sum[15:0]; alu_cy = sum[16]; end
            3'b010: begin sum = {1'b0, alu_x} + {1'b0, alu_y}; alu_z = sum[15:0]; alu_cy = sum[16]; end
            3'b011: alu_z = 16'd0 - alu_x;
            3'b100: alu_z = alu_x | alu_y;
            3'b101: alu_z = ~alu_x;
            3'b110: begin sum = {1'b0, alu_x} + 17'h0FFFF;   alu_z = sum[15:0]; alu_cy = sum[16]; end
            3'b111: alu_z = 16'd0;
            default: ;
        endcase
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_reg(input logic [2:0] sel, input logic [15:0] val);
        @(negedge clock);
        pre_we = 1'b1; pre_sel = sel; pre_data = val;
        @(negedge clock);
        pre_we = 1'b0;
    endtask

    // Issue one instruction; reports cycles from accept edge to done, reads seen, illegal at done
    task automatic run_instr(input logic [2:0] op, rd, rs, rt,
                             output int lat, output int reads, output logic ill, output int rdy_bad);
        int guard;
        lat = 0; reads = 0; ill = 1'b0; rdy_bad = 0; guard = 0;
        @(negedge clock);
        instr_valid = 1'b1; instr_op = op; instr_rd = rd; instr_rs = rs; instr_rt = rt;
        while (!instr_ready && guard < 20) begin
            @(negedge clock);
            guard++;
        end
        @(posedge clock);
        #1 instr_valid = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clock);
            if (reg_read) reads++;
            if (instr_ready) rdy_bad++;
            if (done) begin
                lat = k;
                ill = illegal;
                break;
            end
        end
        @(negedge clock);
    endtask

    typedef struct {
        logic [2:0]  op, rd, rs, rt;
        logic [15:0] xv, yv, ez;
        logic [3:0]  ef;
    } vec_t;

    vec_t vecs[16];

    typedef struct {
        logic [2:0] op, rd, rs, rt;
    } b2b_t;

    b2b_t b2b[3];

    initial begin
        int lat, reads, rdy_bad, exp_lat, exp_reads, dcnt, issued, bad, wr_seen;
        logic ill;

        //            op    rd    rs    rt    x         y         result    ZSCV
        vecs[0]  = '{3'd2, 3'd3, 3'd1, 3'd2, 16'd5,    16'd7,    16'd12,   4'b0000};
        vecs[1]  = '{3'd1, 3'd1, 3'd1, 3'd1, 16'h7FFF, 16'h7FFF, 16'h8000, 4'b0101};
        vecs[2]  = '{3'd1, 3'd5, 3'd4, 3'd4, 16'hFFFF, 16'hFFFF, 16'h0000, 4'b1010};
        vecs[3]  = '{3'd6, 3'd6, 3'd5, 3'd5, 16'h0000, 16'h0000, 16'hFFFF, 4'b0100};
        vecs[4]  = '{3'd7, 3'd2, 3'd2, 3'd2, 16'd9,    16'd9,    16'd9,    4'b0100};
        vecs[5]  = '{3'd3, 3'd7, 3'd3, 3'd3, 16'h0001, 16'h0001, 16'hFFFF, 4'b0110};
        vecs[6]  = '{3'd3, 3'd0, 3'd0, 3'd0, 16'h8000, 16'h8000, 16'h8000, 4'b0111};
        vecs[7]  = '{3'd4, 3'd0, 3'd1, 3'd2, 16'h00F0, 16'h0F00, 16'h0FF0, 4'b0000};
        vecs[8]  = '{3'd5, 3'd2, 3'd2, 3'd2, 16'h00FF, 16'h00FF, 16'hFF00, 4'b0100};
        vecs[9]  = '{3'd0, 3'd4, 3'd6, 3'd6, 16'h0000, 16'h0000, 16'h0000, 4'b1000};
        vecs[10] = '{3'd2, 3'd5, 3'd6, 3'd7, 16'h7FFF, 16'h0001, 16'h8000, 4'b0101};
        vecs[11] = '{3'd2, 3'd1, 3'd2, 3'd3, 16'hFFFF, 16'h0001, 16'h0000, 4'b1010};
        vecs[12] = '{3'd2, 3'd4, 3'd4, 3'd4, 16'h8000, 16'h8000, 16'h0000, 4'b1011};
        vecs[13] = '{3'd4, 3'd6, 3'd6, 3'd6, 16'h8421, 16'h8421, 16'h8421, 4'b0100};
        vecs[14] = '{3'd1, 3'd3, 3'd3, 3'd3, 16'h0000, 16'h0000, 16'h0001, 4'b0000};
        vecs[15] = '{3'd6, 3'd7, 3'd0, 3'd0, 16'h8000, 16'h8000, 16'h7FFF, 4'b0011};

        b2b[0] = '{3'd1, 3'd1, 3'd0, 3'd0};
        b2b[1] = '{3'd2, 3'd2, 3'd1, 3'd1};
        b2b[2] = '{3'd5, 3'd3, 3'd2, 3'd2};

        // Reset state
        repeat (3) @(negedge clock);
        check("rst_ready", instr_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_flags", flags, 4'b0000);
        check("rst_done", done, 0);
        check("rst_write", reg_write, 0);
        reset = 1'b0;

        // Table-driven instructions
        foreach (vecs[i]) begin
            set_reg(vecs[i].rt, vecs[i].yv);
            set_reg(vecs[i].rs, vecs[i].xv);
            run_instr(vecs[i].op, vecs[i].rd, vecs[i].rs, vecs[i].rt, lat, reads, ill, rdy_bad);
            exp_lat   = (vecs[i].op == 3'd7) ? 2 : (vecs[i].op == 3'd2 || vecs[i].op == 3'd4) ? 4 : 3;
            exp_reads = (vecs[i].op == 3'd2 || vecs[i].op == 3'd4) ? 2 : 1;
            check($sformatf("v%0d_latency", i), lat, exp_lat);
            check($sformatf("v%0d_reads", i), reads, exp_reads);
            check($sformatf("v%0d_result", i), bank[vecs[i].rd], vecs[i].ez);
            check($sformatf("v%0d_flags", i), flags, vecs[i].ef);
            check($sformatf("v%0d_illegal", i), ill, (vecs[i].op == 3'd7));
            check($sformatf("v%0d_ready_low", i), rdy_bad, 0);
        end

        // Reset asserted while an add sits in RDY
        set_reg(3'd1, 16'd5);
        set_reg(3'd2, 16'd7);
        set_reg(3'd3, 16'h1234);
        @(negedge clock);
        instr_valid = 1'b1; instr_op = 3'd2; instr_rd = 3'd3; instr_rs = 3'd1; instr_rt = 3'd2;
        @(negedge clock);
        instr_valid = 1'b0;
        @(negedge clock);
        check("rdy_read", reg_read, 1);
        check("rdy_sel", reg_sel, 3'd2);
        reset = 1'b1;
        #1;
        check("async_busy", busy, 0);
        check("async_read", reg_read, 0);
        wr_seen = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clock);
            if (reg_write) wr_seen++;
            if (k == 1) reset = 1'b0;
        end
        check("rst_no_write", wr_seen, 0);
        check("rst_flags_clr", flags, 4'b0000);
        check("rst_ready_after", instr_ready, 1);
        check("rst_r3_kept", bank[3], 16'h1234);

        // Back-to-back with valid held high
        set_reg(3'd0, 16'd10);
        dcnt = 0; issued = 0; bad = 0;
        for (int k = 0; k < 25; k++) begin
            @(negedge clock);
            if (done) dcnt++;
            if (busy && instr_ready) bad++;
            if (instr_ready) begin
                if (issued < 3) begin
                    instr_valid = 1'b1;
                    instr_op = b2b[issued].op; instr_rd = b2b[issued].rd;
                    instr_rs = b2b[issued].rs; instr_rt = b2b[issued].rt;
                    issued++;
                end else begin
                    instr_valid = 1'b0;
                end
            end
        end
        check("b2b_done_count", dcnt, 3);
        check("b2b_ready_busy", bad, 0);
        check("b2b_r1", bank[1], 16'd11);
        check("b2b_r2", bank[2], 16'd22);
        check("b2b_r3", bank[3], 16'hFFE9);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
